// File: rtl/dram_pkg.sv
// Shared types and helpers for the multiplexed-address DRAM receiver.
package dram_pkg;

  localparam int DEF_ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW      = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRIVE = 3'd3,
    WR_HOLD  = 3'd4
  } state_t;

  // Strobes are active low, so "fell" marks assertion and "rose" release.
  function automatic logic fell(input logic prev, input logic cur);
    return prev & ~cur;
  endfunction

  function automatic logic rose(input logic prev, input logic cur);
    return ~prev & cur;
  endfunction

endpackage

// File: rtl/dram_cell_array.sv
// 1-bit-wide cell array: synchronous write, combinational read, no reset.
module dram_cell_array #(
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic             wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic             rdata_o
);

  logic mem [0:(2**IDX_W)-1];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dram_addr_demux.sv
// Demultiplexes RAS/CAS address phases and models a 4116-style 16Kx1 DRAM.
module dram_addr_demux
  import dram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = 2,
  parameter int REF_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ma,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic              din,
  output logic              dout,
  output logic              dout_oe,
  output logic [ADDR_W-1:0] row_q,
  output logic [ADDR_W-1:0] col_q,
  output logic [REF_W-1:0]  ref_cnt,
  output logic              proto_err
);

  localparam int IDX_W = 2 * ADDR_W;
  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic              ras_hist_q, cas_hist_q;
  logic              cas_seen_q, cas_seen_d;
  logic [2:0]        lat_q, lat_d;
  logic              dout_q, dout_d;
  logic              oe_q, oe_d;
  logic [ADDR_W-1:0] row_d, col_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic              err_q, err_d;
  logic              cell_we, cell_rdata;

  logic ras_fall, ras_rise, cas_fall, cas_rise;
  assign ras_fall = fell(ras_hist_q, ras_n);
  assign ras_rise = rose(ras_hist_q, ras_n);
  assign cas_fall = fell(cas_hist_q, cas_n);
  assign cas_rise = rose(cas_hist_q, cas_n);

  // Early write commits on the CAS fall itself, using the incoming column.
  dram_cell_array #(.IDX_W(IDX_W)) u_cells (
    .clk     (clk),
    .we_i    (cell_we & ~rst),
    .waddr_i ({row_q, ma}),
    .wdata_i (din),
    .raddr_i ({row_q, col_q}),
    .rdata_o (cell_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cas_seen_d = cas_seen_q;
    lat_d      = lat_q;
    dout_d     = dout_q;
    oe_d       = oe_q;
    row_d      = row_q;
    col_d      = col_q;
    ref_d      = ref_q;
    err_d      = err_q;
    cell_we    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ras_fall) begin
          row_d      = ma;
          cas_seen_d = 1'b0;
          state_d    = ROW;
          if (cas_fall) err_d = 1'b1;
        end else if (cas_fall) begin
          err_d = 1'b1;
        end
      end

      ROW: begin
        if (ras_rise) begin
          if (!cas_seen_q) ref_d = ref_q + 1'b1;
          state_d = IDLE;
        end else if (cas_fall) begin
          col_d      = ma;
          cas_seen_d = 1'b1;
          if (!we_n) begin
            cell_we = 1'b1;
            state_d = WR_HOLD;
          end else begin
            lat_d   = LAT_LOAD;
            state_d = RD_WAIT;
          end
        end
      end

      RD_WAIT, RD_DRIVE, WR_HOLD: begin
        if (ras_rise) begin
          // Releasing CAS in the same sample is a clean end of cycle.
          if (!cas_rise) err_d = 1'b1;
          oe_d    = 1'b0;
          dout_d  = 1'b0;
          state_d = IDLE;
        end else if (cas_rise) begin
          oe_d    = 1'b0;
          dout_d  = 1'b0;
          state_d = ROW;
        end else if (state_q == RD_WAIT) begin
          if (lat_q == 3'd0) begin
            dout_d  = cell_rdata;
            oe_d    = 1'b1;
            state_d = RD_DRIVE;
          end else begin
            lat_d = lat_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ras_hist_q <= 1'b1;
      cas_hist_q <= 1'b1;
      cas_seen_q <= 1'b0;
      lat_q      <= 3'd0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      ref_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ras_hist_q <= ras_n;
      cas_hist_q <= cas_n;
      cas_seen_q <= cas_seen_d;
      lat_q      <= lat_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ref_q      <= ref_d;
      err_q      <= err_d;
    end
  end

  assign dout      = dout_q;
  assign dout_oe   = oe_q;
  assign ref_cnt   = ref_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_dram_addr_demux.sv
// Directed bench: protocol-level expectation model checked every cycle plus literal pins.
module tb_dram_addr_demux;

  localparam int ADDR_W   = 7;
  localparam int READ_LAT = 2;
  localparam int REF_W    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] ma = '0;
  logic              ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, din = 1'b0;
  logic              dout, dout_oe, proto_err;
  logic [ADDR_W-1:0] row_q, col_q;
  logic [REF_W-1:0]  ref_cnt;

  dram_addr_demux #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .REF_W(REF_W)) dut (
    .clk(clk), .rst(rst), .ma(ma), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .din(din), .dout(dout), .dout_oe(dout_oe), .row_q(row_q), .col_q(col_q),
    .ref_cnt(ref_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Expected outputs, updated by the stimulus tasks right after the edge where they take effect.
  logic              model_mem [0:(2**(2*ADDR_W))-1];
  logic              exp_oe = 1'b0, exp_dout = 1'b0, exp_err = 1'b0;
  logic [ADDR_W-1:0] exp_row = '0, exp_col = '0;
  logic [REF_W-1:0]  exp_ref = '0;
  logic [ADDR_W-1:0] cur_row = '0;
  logic              cas_in_row = 1'b0;
  logic              chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout_oe",   32'(dout_oe),   32'(exp_oe));
      chk("dout",      32'(dout),      32'(exp_dout));
      chk("row_q",     32'(row_q),     32'(exp_row));
      chk("col_q",     32'(col_q),     32'(exp_col));
      chk("ref_cnt",   32'(ref_cnt),   32'(exp_ref));
      chk("proto_err", 32'(proto_err), 32'(exp_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    tick();
    exp_oe = 0; exp_dout = 0; exp_err = 0; exp_row = '0; exp_col = '0; exp_ref = '0;
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    $display("reset");
  endtask

  task automatic ras_lo(input logic [ADDR_W-1:0] r);
    ma = r; ras_n = 1'b0;
    tick();
    exp_row = r; cur_row = r; cas_in_row = 1'b0;
  endtask

  task automatic ras_hi();
    ras_n = 1'b1;
    tick();
    if (!cas_in_row) exp_ref = exp_ref + 1'b1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] c, input logic d);
    ma = c; we_n = 1'b0; din = d; cas_n = 1'b0;
    tick();
    exp_col = c; cas_in_row = 1'b1; model_mem[{cur_row, c}] = d;
    we_n = 1'b1; cas_n = 1'b1;
    tick();
    $display("write row=%02h col=%02h data=%0b", cur_row, c, d);
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] c);
    ma = c; we_n = 1'b1; cas_n = 1'b0;
    tick();
    exp_col = c; cas_in_row = 1'b1;
    repeat (READ_LAT - 1) tick();
    tick();
    exp_oe = 1'b1; exp_dout = model_mem[{cur_row, c}];
    tick();
    cas_n = 1'b1;
    tick();
    exp_oe = 1'b0; exp_dout = 1'b0;
    $display("read  row=%02h col=%02h data=%0b", cur_row, c, dout);
  endtask

  initial begin
    do_reset();

    // Write then read, with literal latency and data pins.
    ras_lo(7'h2A); do_write(7'h15, 1'b1); ras_hi();
    ras_lo(7'h2A);
    ma = 7'h15; we_n = 1'b1; cas_n = 1'b0;
    tick();
    exp_col = 7'h15; cas_in_row = 1'b1;
    tick();
    chk("lit_oe_at_1", 32'(dout_oe), 32'd0);
    tick();
    exp_oe = 1'b1; exp_dout = 1'b1;
    chk("lit_oe_at_2", 32'(dout_oe), 32'd1);
    chk("lit_dout_2a15", 32'(dout), 32'd1);
    chk("lit_err_clean", 32'(proto_err), 32'd0);
    cas_n = 1'b1;
    tick();
    exp_oe = 1'b0; exp_dout = 1'b0;
    $display("read  row=2a col=15 data=1 (latency pinned)");
    ras_hi();

    // Page mode: one RAS low, writes then reads on three columns.
    ras_lo(7'h2A);
    do_write(7'h00, 1'b1); do_write(7'h01, 1'b0); do_write(7'h7F, 1'b1);
    do_read(7'h00); do_read(7'h01); do_read(7'h7F);
    chk("lit_page_row", 32'(row_q), 32'h2A);
    ras_hi();

    // RAS-only refresh over every row.
    for (int r = 0; r < 128; r++) begin
      ras_lo(7'(r)); ras_hi();
    end
    chk("lit_ref_128", 32'(ref_cnt), 32'd128);
    $display("refresh 128 rows ref_cnt=%0d", ref_cnt);
    ras_lo(7'h2A); do_read(7'h15); do_read(7'h01); do_read(7'h7F); ras_hi();

    // Reset in the cycle after a read's CAS fall.
    ras_lo(7'h2A);
    ma = 7'h15; we_n = 1'b1; cas_n = 1'b0;
    tick();
    exp_col = 7'h15;
    rst = 1'b1; ras_n = 1'b1; cas_n = 1'b1;
    tick();
    exp_oe = 0; exp_dout = 0; exp_err = 0; exp_row = '0; exp_col = '0; exp_ref = '0;
    rst = 1'b0;
    repeat (3) tick();
    chk("lit_oe_after_rst", 32'(dout_oe), 32'd0);
    $display("reset mid-read");
    ras_lo(7'h2A); do_read(7'h15); ras_hi();

    // Simultaneous RAS and CAS fall in IDLE.
    ma = 7'h11; ras_n = 1'b0; cas_n = 1'b0;
    tick();
    exp_row = 7'h11; cur_row = 7'h11; cas_in_row = 1'b0; exp_err = 1'b1;
    chk("lit_sim_row", 32'(row_q), 32'h11);
    chk("lit_sim_err", 32'(proto_err), 32'd1);
    cas_n = 1'b1;
    tick();
    $display("simultaneous RAS/CAS fall row=11");
    do_write(7'h05, 1'b1); do_read(7'h05); ras_hi();

    // Protocol errors: CAS-before-RAS, then RAS released before CAS.
    do_reset();
    cas_n = 1'b0;
    tick();
    exp_err = 1'b1;
    cas_n = 1'b1;
    tick();
    ras_lo(7'h2A); do_read(7'h15); ras_hi();
    chk("lit_err_sticky", 32'(proto_err), 32'd1);
    $display("CAS fall in IDLE");
    do_reset();
    ras_lo(7'h2A);
    ma = 7'h15; we_n = 1'b1; cas_n = 1'b0;
    tick();
    exp_col = 7'h15; cas_in_row = 1'b1;
    ras_n = 1'b1;
    tick();
    exp_err = 1'b1; exp_oe = 1'b0; exp_dout = 1'b0;
    cas_n = 1'b1;
    tick();
    chk("lit_early_ras_err", 32'(proto_err), 32'd1);
    $display("RAS rise with CAS low");
    // A clean cycle afterwards proves the return to IDLE.
    ras_lo(7'h2A); do_read(7'h00); ras_hi();

    // Simultaneous CAS and RAS rise ends a cycle without error.
    do_reset();
    ras_lo(7'h2A);
    ma = 7'h01; we_n = 1'b1; cas_n = 1'b0;
    tick();
    exp_col = 7'h01; cas_in_row = 1'b1;
    ras_n = 1'b1; cas_n = 1'b1;
    tick();
    tick();
    chk("lit_joint_rise_err", 32'(proto_err), 32'd0);
    $display("simultaneous RAS/CAS rise");

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
